mem_copy_dma: RTL
=================

Name: mem_copy_dma

Overview:
- Bus initiator on the picorv32 native memory interface: mem_valid, mem_ready, mem_instr, mem_wstrb, mem_addr, mem_wdata, mem_rdata.
- Copies COUNT 32-bit words from a source address to a destination address, one word at a time.
- Each word is a read transaction followed by a write transaction.
- Sits beside the CPU as a second master, arbitrated externally. It drives the same memory controllers and peripherals the CPU does.

Parameters:
- TIMEOUT, 256, max cycles mem_valid may stay high without mem_ready before the transfer is aborted (range 2..65535).
- CNT_W, 16, width of the word-count input and counters.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- count  in  CNT_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- words_left  out  CNT_W  remaining word count.
- mem_valid  out  1  transaction request.
- mem_ready  in  1  responder completion.
- mem_instr  out  1  constant 0.
- mem_wstrb  out  4  0000 for a read, 1111 for a write.
- mem_addr  out  32  word-aligned address; [1:0] always 00.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid when mem_ready=1.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: busy=0, done=0, error=0, words_left=0, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - State: IDLE; internal data buffer = 0.
- Handshake:
  - While mem_valid=1, mem_addr, mem_wstrb and mem_wdata are held stable.
  - A transaction completes at the rising edge where mem_valid=1 and mem_ready=1.
  - mem_valid drops in the following cycle and stays low for at least one full cycle (GAP) before the next request.
  - mem_ready while mem_valid=0 is ignored.
- States:
  - IDLE:
    - start=1 and count>0: latch src/dst (with [1:0] cleared), words_left=count, error=0, go to READ.
    - start=1 and count=0: error=0, done pulses next cycle, no bus activity, stay in IDLE.
  - READ: mem_valid=1, wstrb=0000, addr=src. On ready: buffer<=mem_rdata, go to RGAP.
  - RGAP: mem_valid=0, one cycle, then WRITE.
  - WRITE: mem_valid=1, wstrb=1111, addr=dst, wdata=buffer. On ready:
    - src+=4, dst+=4, words_left-=1.
    - If words_left was 1: go to FIN. Otherwise go to WGAP.
  - WGAP: mem_valid=0, one cycle, then READ.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Timeout:
  - A wait counter resets on entry to READ or WRITE and increments each cycle without ready.
  - If TIMEOUT cycles elapse in READ or WRITE with no ready: mem_valid=0 next cycle, error=1, no done pulse, go to IDLE.
  - words_left keeps the residual count.
- Addresses add modulo 2^32: 0xFFFFFFFC+4 wraps to 0x00000000.
- start while busy is ignored; inputs are not re-sampled.
- Throughput with a responder that answers in the same cycle: 4 cycles per word.
  - First mem_valid is seen the cycle after start.
  - done asserts 4*count+1 cycles after the start edge.
- Reset mid-transfer:
  - mem_valid drops immediately (async); no done or error pulse.
  - Any write in flight may or may not land; the bench does not check it.

Test Plan:
- Memory model, zero-wait. Preload 0x100..0x10C = 11,22,33,44; start src=0x100, dst=0x200, count=4 -> 0x200..0x20C = 11,22,33,44. done pulses exactly once, 17 cycles after start. Every mem_addr seen has [1:0]=00, wstrb alternates 0000/1111, and a low mem_valid cycle separates every transaction.
- count=0 -> done the next cycle, busy stays 0, mem_valid never rises.
- Responder inserts 3 wait cycles on each ready, count=2 -> addr/wstrb/wdata stay stable during the waits, data copied correctly, done at cycle 2*(4+6)+1.
- Responder never asserts ready, TIMEOUT=8 -> mem_valid drops after 8 cycles, error=1, words_left=count, no done. A following start with a good responder clears error and completes.
- src=0xFFFFFFFC, count=2 -> second read address is 0x00000000.
- Pulse start again mid-copy -> ignored, original copy completes.
- Deassert resetn during WRITE -> mem_valid=0 and busy=0 immediately; a later start behaves normally.

Source files
------------

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-by-word memory copy engine acting as a second bus master
// on the picorv32 native memory interface. Each word is one read followed by
// one write, with a one-cycle idle gap after every completed transaction and a
// per-transaction timeout that aborts the copy if the responder never answers.
module mem_copy_dma #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_left,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_instr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RGAP,
    S_WRITE,
    S_WGAP,
    S_FIN
  } state_t;

  // Wait counter value at which the TIMEOUT-th stalled cycle ends.
  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      buf_q, buf_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [15:0]      wait_q, wait_d;
  logic             error_q, error_d;
  logic             done_q, done_d;

  // State and datapath registers; async assert, release follows the clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      buf_q   <= 32'h0;
      left_q  <= '0;
      wait_q  <= 16'h0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      left_q  <= left_d;
      wait_q  <= wait_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: sequencing, handshake completion and timeout abort.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    left_d  = left_q;
    wait_d  = wait_q;
    error_d = error_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (count != '0) begin
            src_d   = src_addr & WORD_MASK;
            dst_d   = dst_addr & WORD_MASK;
            left_d  = count;
            wait_d  = 16'h0;
            state_d = S_READ;
          end else begin
            // Empty copy: report completion without touching the bus.
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = S_RGAP;
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RGAP: begin
        wait_d  = 16'h0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          left_d  = left_q - CNT_ONE;
          state_d = (left_q == CNT_ONE) ? S_FIN : S_WGAP;
        end else if (wait_q == WAIT_LAST) begin
          // Residual count is kept so software can see how far it got.
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WGAP: begin
        wait_d  = 16'h0;
        state_d = S_READ;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from registered state so they are held stable while
  // a request is pending and drop immediately on reset.
  always_comb begin
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    busy      = 1'b0;
    unique case (state_q)
      S_READ: begin
        mem_valid = 1'b1;
        mem_addr  = src_q;
        busy      = 1'b1;
      end
      S_WRITE: begin
        mem_valid = 1'b1;
        mem_wstrb = 4'b1111;
        mem_addr  = dst_q;
        mem_wdata = buf_q;
        busy      = 1'b1;
      end
      S_RGAP, S_WGAP: busy = 1'b1;
      default: ;
    endcase
  end

  assign mem_instr  = 1'b0;
  assign done       = done_q;
  assign error      = error_q;
  assign words_left = left_q;

endmodule
